// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-latch enable/flush generation for stalls,
// redirects, load-use bubbles and halt, with saturating stall/flush counters.
module hazard_ctrl #(
  parameter int NSTAGES = 5,
  parameter int CNTW    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dmem_req,
  input  logic              dhit,
  input  logic              load_use,
  input  logic              redirect,
  input  logic [2:0]        redirect_stage,
  input  logic              halt,
  output logic              pc_en,
  output logic [NSTAGES-2:0] latch_en,
  output logic [NSTAGES-2:0] latch_flush,
  output logic              halted,
  output logic [CNTW-1:0]   stall_cnt,
  output logic [CNTW-1:0]   flush_cnt
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [2:0] LAST = 3'(NSTAGES - 1);

  state_t          r_state, w_state_nxt;
  logic            r_pend;
  logic [2:0]      r_pend_stage;
  logic            r_halt_pend;
  logic [CNTW-1:0] r_stall_cnt;
  logic [CNTW-1:0] r_flush_cnt;

  logic       w_mstall;
  logic [2:0] w_rs;
  logic [2:0] w_req_s;
  logic [2:0] w_pend_s;
  logic [2:0] w_s;
  logic       w_apply;
  logic       w_stall_any;

  assign w_mstall = dmem_req && !dhit;
  assign w_rs     = (redirect_stage == 3'd0 || redirect_stage > LAST) ? LAST : redirect_stage;
  assign w_req_s  = redirect ? w_rs : 3'd0;
  assign w_pend_s = r_pend ? r_pend_stage : 3'd0;
  assign w_s      = (w_req_s > w_pend_s) ? w_req_s : w_pend_s;

  always_comb begin
    pc_en       = 1'b1;
    latch_en    = '1;
    latch_flush = '0;
    halted      = 1'b0;
    w_apply     = 1'b0;
    if (RST) begin
      pc_en       = 1'b0;
      latch_en    = '0;
      latch_flush = '1;
    end else if (r_state == HALTED) begin
      pc_en    = 1'b0;
      latch_en = '0;
      halted   = 1'b1;
    end else if (w_mstall) begin
      pc_en    = 1'b0;
      latch_en = '0;
    end else if (redirect || r_pend) begin
      w_apply = 1'b1;
      for (int i = 0; i < NSTAGES - 1; i++) begin
        latch_flush[i] = (3'(i) < w_s);
      end
    end else if (load_use) begin
      pc_en          = 1'b0;
      latch_en[0]    = 1'b0;
      latch_flush[1] = 1'b1;
    end else if (!ihit) begin
      pc_en          = 1'b0;
      latch_flush[0] = 1'b1;
    end
  end

  assign w_stall_any = !pc_en || !(&latch_en);

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == RUN && (halt || r_halt_pend) && !w_mstall) begin
      w_state_nxt = HALTED;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Redirects and halts seen during a memory stall are held until it releases.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pend       <= 1'b0;
      r_pend_stage <= 3'd0;
      r_halt_pend  <= 1'b0;
    end else if (r_state == RUN) begin
      if (w_mstall) begin
        if (redirect) begin
          r_pend       <= 1'b1;
          r_pend_stage <= w_s;
        end
        if (halt) begin
          r_halt_pend <= 1'b1;
        end
      end else begin
        r_pend       <= 1'b0;
        r_pend_stage <= 3'd0;
        r_halt_pend  <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state == RUN) begin
      if (w_stall_any && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + CNTW'(1);
      end
      if (w_apply && r_flush_cnt != '1) begin
        r_flush_cnt <= r_flush_cnt + CNTW'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter NSTAGES, default 5, number of pipeline stages (legal 3..8); stage 0 = fetch; latch i sits between stage i and stage i+1, i = 0..NSTAGES-2.
REQ-002 Parameter CNTW, default 16, width of the performance counters.
REQ-003 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 ihit  in  1  instruction fetch complete this cycle.
REQ-006 dmem_req  in  1  memory stage holds a load or store.
REQ-007 dhit  in  1  data access complete this cycle.
REQ-008 load_use  in  1  level; decode consumes a load result still in execute.
REQ-009 redirect  in  1  single-cycle pulse; jump or taken branch resolved.
REQ-010 redirect_stage  in  3  stage index resolving the redirect, legal 1..NSTAGES-1.
REQ-011 halt  in  1  halt instruction reached the last stage.
REQ-012 pc_en  out  1  PC update enable.
REQ-013 latch_en  out  NSTAGES-1  per-latch write enable.
REQ-014 latch_flush  out  NSTAGES-1  per-latch bubble insert; when set, the latch loads a NOP.
REQ-015 halted  out  1  pipeline permanently stopped.
REQ-016 stall_cnt  out  CNTW  cycles with any frozen latch.
REQ-017 flush_cnt  out  CNTW  redirects applied.

Function
REQ-018 The block SHALL implement states RUN and HALTED, plus a pending-redirect register (pend valid bit, 3-bit pend_stage).
REQ-019 Outputs SHALL be combinational from the state, the pend register and the inputs, in the priority order of REQ-020 to REQ-025; the highest-priority matching rule wins.
REQ-020 HALTED: pc_en = 0; latch_en all 0; latch_flush all 0; halted = 1; the block SHALL remain in HALTED until RST.
REQ-021 Memory stall (dmem_req && !dhit): pc_en = 0; latch_en all 0; latch_flush all 0.
REQ-022 Redirect apply (redirect, or pend, with no memory stall): the effective stage s SHALL be the larger of redirect_stage and pend_stage; latch_flush[i] = 1 for i < s; all latch_en = 1; pc_en = 1; pend SHALL clear; flush_cnt SHALL increment by 1.
REQ-023 Load-use: pc_en = 0; latch_en[0] = 0; latch_flush[1] = 1; all other latches advance.
REQ-024 Fetch miss (!ihit): pc_en = 0; latch_en[0] = 1 with latch_flush[0] = 1; all other latches advance.
REQ-025 Otherwise: pc_en = 1; all latch_en = 1; all latch_flush = 0.
REQ-026 A redirect pulse arriving during a memory stall SHALL set pend with pend_stage = redirect_stage; a second pulse while pend is set SHALL keep the larger stage; pend SHALL be applied in the first cycle without a memory stall.
REQ-027 halt in RUN SHALL move the state to HALTED on the next edge; if a memory stall is active, the transition SHALL wait until dhit.
REQ-028 stall_cnt SHALL increment in every RUN cycle where pc_en = 0 or any latch_en bit = 0.
REQ-029 Both counters SHALL saturate at 2^CNTW-1 and SHALL hold in HALTED.
REQ-030 redirect_stage values outside 1..NSTAGES-1 SHALL be clamped to NSTAGES-1.

Reset
REQ-031 On RST at a rising edge: state SHALL be RUN; pend SHALL clear; both counters SHALL be 0.
REQ-032 While RST is high: pc_en = 0; latch_en all 0; latch_flush all 1; halted = 0.
REQ-033 RST SHALL override a memory stall, a pending redirect or HALTED within the same edge.

Verification
REQ-034 NSTAGES=5; ihit=1; other inputs 0 -> pc_en=1; latch_en=4'b1111; latch_flush=0; stall_cnt stays 0.
REQ-035 dmem_req=1 with dhit=0 for 3 cycles, redirect pulse stage 2 in cycle 1 -> all latch_en=0 for 3 cycles; on the dhit cycle latch_flush=4'b0011; flush_cnt=1; stall_cnt=3.
REQ-036 Two redirect pulses (stage 1, then stage 3) during a memory stall -> on release latch_flush=4'b0111; flush_cnt=1.
REQ-037 load_use=1 with ihit=1 -> pc_en=0; latch_en=4'b1110; latch_flush=4'b0010.
REQ-038 halt pulse while dmem_req=1 and dhit=0 -> halted stays 0 until the cycle after dhit, then halted=1 with all enables 0; RST then returns halted=0 and counters=0.
REQ-039 CNTW=2; hold load_use for 5 cycles -> stall_cnt saturates at 3.
